// File: rtl/game_pkg.sv
// Shared encodings and helpers for the breakout game sequencer.
// The visible game_state code collapses the internal SERVE state into PLAY.
package game_pkg;

    localparam int N_BRICKS = 50;
    localparam int SCORE_W  = 16;
    localparam int POP_W    = 6;
    localparam int SUM_W    = 23;

    typedef enum logic [1:0] {
        GS_IDLE = 2'b00,
        GS_PLAY = 2'b01,
        GS_WIN  = 2'b10,
        GS_END  = 2'b11
    } game_state_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_PLAY,
        ST_WIN,
        ST_END
    } ctrl_state_t;

    function automatic logic [POP_W-1:0] popcount(input logic [N_BRICKS-1:0] vec);
        logic [POP_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_BRICKS; i++) begin
            cnt = cnt + POP_W'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/breakout_game_ctrl_btn_debounce.sv
// Start button conditioner: 2-FF synchronizer, stable-count debounce and a
// single press pulse on the debounced falling edge (button is active-low).
module btn_debounce #(
    parameter int DEB_CYCLES = 500_000
) (
    input  logic vga_clk,
    input  logic sys_rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

    logic [1:0]       sync_reg;
    logic             stable_reg;
    logic             stable_d_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             press_reg;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_reg     <= 2'b11;
            stable_reg   <= 1'b1;
            stable_d_reg <= 1'b1;
            cnt_reg      <= '0;
            press_reg    <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[0], btn_n};
            stable_d_reg <= stable_reg;
            press_reg    <= stable_d_reg & ~stable_reg;
            // Any bounce back to the accepted level restarts the stability window.
            if (sync_reg[1] == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
                stable_reg <= sync_reg[1];
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: IDLE/SERVE/PLAY/WIN/END FSM, lives, serve delay and
// saturating score. Optional macro GAME_AUTO_RESTART_EN adds a timed WIN/END exit.
module breakout_game_ctrl
    import game_pkg::*;
#(
    parameter int DEB_CYCLES     = 500_000,
    parameter int SERVE_FRAMES   = 60,
    parameter int LIVES_INIT     = 3,
    parameter int LIVES_W        = 2,
    parameter int POINTS_PER_BRK = 10,
    parameter int RESTART_FRAMES = 180
) (
    input  logic                vga_clk,
    input  logic                sys_rst_n,
    input  logic                btn_start_n,
    input  logic                frame_tick,
    input  logic                ball_lost,
    input  logic                win_sig,
    input  logic [N_BRICKS-1:0] brick_collision,
    output logic [1:0]          game_state,
    output logic                game_reset,
    output logic                ball_launch,
    output logic [SCORE_W-1:0]  score,
    output logic [LIVES_W-1:0]  lives
);

    localparam int SERVE_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    logic press;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn_debounce (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .btn_n     (btn_start_n),
        .press     (press)
    );

    ctrl_state_t        state_reg;
    game_state_t        game_state_reg;
    logic               game_reset_reg;
    logic               ball_launch_reg;
    logic [SCORE_W-1:0] score_reg;
    logic [LIVES_W-1:0] lives_reg;
    logic [SERVE_W-1:0] serve_cnt_reg;

`ifdef GAME_AUTO_RESTART_EN
    localparam int RESTART_W = (RESTART_FRAMES > 1) ? $clog2(RESTART_FRAMES) : 1;
    logic [RESTART_W-1:0] restart_cnt_reg;
`endif

    logic [POP_W-1:0]   hit_cnt;
    logic [SUM_W-1:0]   score_sum;
    logic [SCORE_W-1:0] score_next;

    assign hit_cnt    = popcount(brick_collision);
    assign score_sum  = SUM_W'(score_reg) + SUM_W'(hit_cnt) * SUM_W'(POINTS_PER_BRK);
    assign score_next = (score_sum > SUM_W'(16'hFFFF)) ? 16'hFFFF : score_sum[SCORE_W-1:0];

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg       <= ST_IDLE;
            game_state_reg  <= GS_IDLE;
            game_reset_reg  <= 1'b0;
            ball_launch_reg <= 1'b0;
            score_reg       <= '0;
            lives_reg       <= LIVES_W'(LIVES_INIT);
            serve_cnt_reg   <= '0;
`ifdef GAME_AUTO_RESTART_EN
            restart_cnt_reg <= '0;
`endif
        end else begin
            game_reset_reg  <= 1'b0;
            ball_launch_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (press) begin
                        state_reg      <= ST_SERVE;
                        game_state_reg <= GS_PLAY;
                        game_reset_reg <= 1'b1;
                        score_reg      <= '0;
                        lives_reg      <= LIVES_W'(LIVES_INIT);
                        serve_cnt_reg  <= '0;
                    end
                end
                ST_SERVE: begin
                    // A tick right after game_reset is skipped so the two pulses never abut.
                    if (frame_tick && !game_reset_reg) begin
                        if (serve_cnt_reg == SERVE_W'(SERVE_FRAMES - 1)) begin
                            state_reg       <= ST_PLAY;
                            ball_launch_reg <= 1'b1;
                            serve_cnt_reg   <= '0;
                        end else begin
                            serve_cnt_reg <= serve_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    score_reg <= score_next;
                    if (win_sig) begin
                        state_reg      <= ST_WIN;
                        game_state_reg <= GS_WIN;
`ifdef GAME_AUTO_RESTART_EN
                        restart_cnt_reg <= '0;
`endif
                    end else if (ball_lost) begin
                        if (lives_reg == LIVES_W'(1)) begin
                            lives_reg      <= '0;
                            state_reg      <= ST_END;
                            game_state_reg <= GS_END;
`ifdef GAME_AUTO_RESTART_EN
                            restart_cnt_reg <= '0;
`endif
                        end else begin
                            lives_reg     <= lives_reg - 1'b1;
                            serve_cnt_reg <= '0;
                            state_reg     <= ST_SERVE;
                        end
                    end
                end
                ST_WIN, ST_END: begin
                    if (press) begin
                        state_reg      <= ST_IDLE;
                        game_state_reg <= GS_IDLE;
                    end
`ifdef GAME_AUTO_RESTART_EN
                    else if (frame_tick) begin
                        if (restart_cnt_reg == RESTART_W'(RESTART_FRAMES - 1)) begin
                            state_reg      <= ST_IDLE;
                            game_state_reg <= GS_IDLE;
                        end else begin
                            restart_cnt_reg <= restart_cnt_reg + 1'b1;
                        end
                    end
`endif
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    game_state_reg <= GS_IDLE;
                end
            endcase
        end
    end

    assign game_state  = game_state_reg;
    assign game_reset  = game_reset_reg;
    assign ball_launch = ball_launch_reg;
    assign score       = score_reg;
    assign lives       = lives_reg;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Scoreboard bench for breakout_game_ctrl: stimulus queues expected events,
// a negedge monitor pops one per observed pulse or output change.
`timescale 1ns/1ps
module tb_breakout_game_ctrl;

    localparam int DEB     = 4;
    localparam int SERVE   = 3;
    localparam int RESTART = 5;

    localparam int K_SNAP   = 0;
    localparam int K_RST    = 1;
    localparam int K_LAUNCH = 2;
    localparam int K_CHG    = 3;

    logic        vga_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        btn_start_n = 1'b1;
    logic        frame_tick = 1'b0;
    logic        ball_lost = 1'b0;
    logic        win_sig = 1'b0;
    logic [49:0] brick_collision = '0;
    logic [1:0]  game_state;
    logic        game_reset;
    logic        ball_launch;
    logic [15:0] score;
    logic [1:0]  lives;

    always #5 vga_clk = ~vga_clk;

    breakout_game_ctrl #(
        .DEB_CYCLES     (DEB),
        .SERVE_FRAMES   (SERVE),
        .LIVES_INIT     (3),
        .LIVES_W        (2),
        .POINTS_PER_BRK (10),
        .RESTART_FRAMES (RESTART)
    ) dut (
        .vga_clk         (vga_clk),
        .sys_rst_n       (sys_rst_n),
        .btn_start_n     (btn_start_n),
        .frame_tick      (frame_tick),
        .ball_lost       (ball_lost),
        .win_sig         (win_sig),
        .brick_collision (brick_collision),
        .game_state      (game_state),
        .game_reset      (game_reset),
        .ball_launch     (ball_launch),
        .score           (score),
        .lives           (lives)
    );

    typedef struct {
        int          kind;
        logic [1:0]  gs;
        logic [15:0] score;
        logic [1:0]  lives;
    } rec_t;

    rec_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   mon_en = 0;
    bit   first = 1;
    bit   prev_pulse = 0;
    logic [1:0]  p_gs;
    logic [15:0] p_score;
    logic [1:0]  p_lives;

    // expectation model
    logic [1:0] m_gs = 2'b00;
    int         m_score = 0;
    logic [1:0] m_lives = 2'd3;

    function automatic string kname(input int k);
        case (k)
            K_SNAP:   return "reset_state";
            K_RST:    return "game_reset";
            K_LAUNCH: return "ball_launch";
            default:  return "change";
        endcase
    endfunction

    task automatic expect_ev(input int k);
        rec_t r;
        r.kind  = k;
        r.gs    = m_gs;
        r.score = 16'(m_score);
        r.lives = m_lives;
        exp_q.push_back(r);
    endtask

    always @(negedge vga_clk) begin : monitor
        int   k;
        rec_t r;
        bit   bad;
        if (mon_en) begin
            k = -1;
            if (first)
                k = K_SNAP;
            else if (game_reset)
                k = K_RST;
            else if (ball_launch)
                k = K_LAUNCH;
            else if ({game_state, score, lives} !== {p_gs, p_score, p_lives})
                k = K_CHG;
            if (k >= 0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_%s: got gs=%b score=%h lives=%0d rst=%b launch=%b, required no event",
                             kname(k), game_state, score, lives, game_reset, ball_launch);
                end else begin
                    r = exp_q.pop_front();
                    bad = (r.kind != k) || (r.gs !== game_state) || (r.score !== score) ||
                          (r.lives !== lives) || (game_reset && ball_launch) ||
                          ((game_reset || ball_launch) && prev_pulse);
                    if (bad) begin
                        n_fail++;
                        $display("FAIL %s: got %s gs=%b score=%h lives=%0d rst=%b launch=%b prev_pulse=%b, required gs=%b score=%h lives=%0d",
                                 kname(r.kind), kname(k), game_state, score, lives, game_reset,
                                 ball_launch, prev_pulse, r.gs, r.score, r.lives);
                    end else begin
                        $display("ok   %s gs=%b score=%h lives=%0d", kname(k), game_state, score, lives);
                    end
                end
            end
            first      = 0;
            prev_pulse = game_reset | ball_launch;
            p_gs       = game_state;
            p_score    = score;
            p_lives    = lives;
        end
    end

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic press_button();
        btn_start_n = 1'b0;
        repeat (20) step();
        btn_start_n = 1'b1;
        repeat (20) step();
    endtask

    task automatic frame_pulse();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (3) step();
    endtask

    task automatic serve();
        frame_pulse();
        frame_pulse();
        expect_ev(K_LAUNCH);
        frame_pulse();
    endtask

    // pop is the hand-counted number of set bits in v
    task automatic hit(input logic [49:0] v, input int pop);
        int ns;
        ns = m_score + pop * 10;
        if (ns > 65535) ns = 65535;
        if (ns != m_score) begin
            m_score = ns;
            expect_ev(K_CHG);
        end
        brick_collision = v;
        step();
        brick_collision = '0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL timeout: got no finish, required finish within 2ms");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [49:0] v;
        repeat (3) step();
        sys_rst_n = 1'b1;
        expect_ev(K_SNAP);
        mon_en = 1;
        repeat (5) step();

        // game 1 start
        m_gs = 2'b01; m_score = 0; m_lives = 2'd3;
        expect_ev(K_RST);
        press_button();

        // ignored during SERVE
        ball_lost = 1'b1; win_sig = 1'b1; brick_collision = '1;
        step();
        ball_lost = 1'b0; win_sig = 1'b0; brick_collision = '0;
        repeat (2) step();
        serve();

        hit(50'b1110, 3);
        v = '0; v[0] = 1; v[9] = 1; v[10] = 1; v[25] = 1; v[49] = 1;
        hit(v, 5);

        // collision and ball loss in the same cycle
        m_score = 90; m_lives = 2'd2;
        expect_ev(K_CHG);
        ball_lost = 1'b1; brick_collision = 50'b10000;
        step();
        ball_lost = 1'b0; brick_collision = '0;
        repeat (2) step();
        serve();

        // climb to 16'hFFF0, then saturate
        for (int i = 0; i < 130; i++) hit('1, 50);
        v = '0;
        for (int i = 0; i < 43; i++) v[i] = 1'b1;
        hit(v, 43);
        hit(50'b11, 2);
        hit(50'b1, 1);
        repeat (2) step();

        press_button();

        m_lives = 2'd1;
        expect_ev(K_CHG);
        ball_lost = 1'b1; step(); ball_lost = 1'b0;
        repeat (2) step();
        serve();

        m_lives = 2'd0; m_gs = 2'b11;
        expect_ev(K_CHG);
        ball_lost = 1'b1; step(); ball_lost = 1'b0;
        repeat (3) step();

        m_gs = 2'b00;
        expect_ev(K_CHG);
        press_button();

        // game 2
        m_gs = 2'b01; m_score = 0; m_lives = 2'd3;
        expect_ev(K_RST);
        press_button();
        serve();

        m_gs = 2'b10;
        expect_ev(K_CHG);
        win_sig = 1'b1; ball_lost = 1'b1;
        step();
        ball_lost = 1'b0;
        repeat (3) step();
        win_sig = 1'b0;
        repeat (2) step();

`ifdef GAME_AUTO_RESTART_EN
        repeat (RESTART - 1) frame_pulse();
        m_gs = 2'b00;
        expect_ev(K_CHG);
        frame_pulse();
`else
        repeat (8) frame_pulse();
        m_gs = 2'b00;
        expect_ev(K_CHG);
        press_button();
`endif

        repeat (10) step();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events: got %0d still queued, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
